// File: rtl/gate_array_pkg.sv
// Shared types for the gate array pipeline: opcode encoding and per-result sideband record.
package gate_array_pkg;

    typedef enum logic [2:0] {
        OP_AND  = 3'd0,
        OP_OR   = 3'd1,
        OP_NAND = 3'd2,
        OP_NOR  = 3'd3,
        OP_XOR  = 3'd4,
        OP_XNOR = 3'd5,
        OP_NOT  = 3'd6,
        OP_PASS = 3'd7
    } op_e;

    // The y field is width-dependent, so the full result record is built in the top
    // around this fixed-width sideband.
    typedef struct packed {
        op_e  op;
        logic zero;
        logic parity;
    } res_meta_t;

endpackage

// File: rtl/gate_array_fn.sv
// Combinational bitwise function unit: applies the selected logic op and derives zero/parity flags.
module gate_array_fn
    import gate_array_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    output logic [WIDTH-1:0] y,
    output logic             zero,
    output logic             parity
);

    function automatic logic calc_parity(input logic [WIDTH-1:0] v);
        return ^v;
    endfunction

    // Opcode decode to the bitwise result.
    always_comb begin
        y = a;
        case (op_e'(op))
            OP_AND:  y = a & b;
            OP_OR:   y = a | b;
            OP_NAND: y = ~(a & b);
            OP_NOR:  y = ~(a | b);
            OP_XOR:  y = a ^ b;
            OP_XNOR: y = ~(a ^ b);
            OP_NOT:  y = ~a;
            OP_PASS: y = a;
            default: y = a;
        endcase
    end

    assign zero   = (y == {WIDTH{1'b0}});
    assign parity = calc_parity(y);

endmodule

// File: rtl/gate_array_pipe.sv
// Pipelined gate array: registers each result into a main/skid buffer pair behind a valid/ready
// stream, keeping full throughput under backpressure, plus a saturating accepted-transaction count.
module gate_array_pipe
    import gate_array_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [2:0]       in_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_y,
    output logic [2:0]       out_op,
    output logic             out_zero,
    output logic             out_parity,
    output logic [CNT_W-1:0] txn_count
);

    typedef struct packed {
        logic [WIDTH-1:0] y;
        res_meta_t        meta;
    } res_t;

    logic [WIDTH-1:0] fn_y_s;
    logic             fn_zero_s;
    logic             fn_parity_s;
    res_t             new_s;
    res_t             m_r, s_r, m_nxt_s, s_nxt_s;
    logic             m_valid_r, s_valid_r, m_valid_nxt_s, s_valid_nxt_s;
    logic             accept_s, drain_s;
    logic [CNT_W-1:0] cnt_r, cnt_nxt_s;

    gate_array_fn #(.WIDTH(WIDTH)) u_fn (
        .a      (in_a),
        .b      (in_b),
        .op     (in_op),
        .y      (fn_y_s),
        .zero   (fn_zero_s),
        .parity (fn_parity_s)
    );

    assign new_s.y           = fn_y_s;
    assign new_s.meta.op     = op_e'(in_op);
    assign new_s.meta.zero   = fn_zero_s;
    assign new_s.meta.parity = fn_parity_s;

    // in_ready depends only on registered skid occupancy, never on out_ready.
    assign accept_s = in_valid && !s_valid_r;
    assign drain_s  = m_valid_r && out_ready;

    // Buffer next-state: M fills first, S absorbs one result when M is stalled.
    always_comb begin
        m_nxt_s       = m_r;
        s_nxt_s       = s_r;
        m_valid_nxt_s = m_valid_r;
        s_valid_nxt_s = s_valid_r;
        if (accept_s && (!m_valid_r || drain_s)) begin
            m_nxt_s       = new_s;
            m_valid_nxt_s = 1'b1;
        end else if (accept_s) begin
            s_nxt_s       = new_s;
            s_valid_nxt_s = 1'b1;
        end else if (drain_s && s_valid_r) begin
            m_nxt_s       = s_r;
            s_valid_nxt_s = 1'b0;
        end else if (drain_s) begin
            m_valid_nxt_s = 1'b0;
        end else begin
            m_valid_nxt_s = m_valid_r;
        end
    end

    // Saturating counter next-state.
    always_comb begin
        cnt_nxt_s = cnt_r;
        if (accept_s && (cnt_r != {CNT_W{1'b1}})) begin
            cnt_nxt_s = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            cnt_nxt_s = cnt_r;
        end
    end

    // State registers; reset discards any buffered result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_r       <= '0;
            s_r       <= '0;
            m_valid_r <= 1'b0;
            s_valid_r <= 1'b0;
            cnt_r     <= {CNT_W{1'b0}};
        end else begin
            m_r       <= m_nxt_s;
            s_r       <= s_nxt_s;
            m_valid_r <= m_valid_nxt_s;
            s_valid_r <= s_valid_nxt_s;
            cnt_r     <= cnt_nxt_s;
        end
    end

    assign in_ready   = !s_valid_r;
    assign out_valid  = m_valid_r;
    assign out_y      = m_r.y;
    assign out_op     = m_r.meta.op;
    assign out_zero   = m_r.meta.zero;
    assign out_parity = m_r.meta.parity;
    assign txn_count  = cnt_r;

endmodule

// File: doc/gate_array_pipe.md
Name: gate_array_pipe

Overview:
- Parametrised, pipelined successor to the two-input basic-gate block.
- Applies one of eight bitwise logic functions to WIDTH-bit operand vectors, selected per transaction by an opcode.
- Result is registered and delivered over a valid/ready stream with a 2-entry output buffer, so throughput stays at 1 result/cycle under backpressure.
- Also produces reduction flags and a saturating transaction counter.
- Sits between an operand source and any stream consumer in the datapath test fabric.

Parameters:
- WIDTH, 8, operand and result width in bits (≥1)
- CNT_W, 16, width of the accepted-transaction counter (≥2)

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operand transaction valid
- in_ready  out  1  block can accept a transaction this cycle
- in_a  in  WIDTH  operand A
- in_b  in  WIDTH  operand B
- in_op  in  3  opcode: 0 AND, 1 OR, 2 NAND, 3 NOR, 4 XOR, 5 XNOR, 6 NOT A, 7 PASS A
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- out_y  out  WIDTH  result vector
- out_op  out  3  opcode echoed with its result
- out_zero  out  1  out_y == 0
- out_parity  out  1  XOR-reduction of out_y
- txn_count  out  CNT_W  accepted input transactions, saturating

Behaviour:
- Reset (rst_n low, asynchronous):
  - out_valid=0, out_y=0, out_op=0, out_zero=0, out_parity=0, txn_count=0.
  - Both buffer entries empty.
  - in_ready=1 during and after reset.
- Storage:
  - Main register M drives the out_* ports.
  - Skid register S holds one overflow result.
- Handshake:
  - Input handshake = in_valid && in_ready.
  - Output handshake = out_valid && out_ready.
  - in_ready = !S_valid (registered state only, no combinational path from out_ready).
- Latency: a result accepted in cycle N is visible on out_* in cycle N+1 if M is empty or drains in cycle N.
- Per-cycle update, given accept (input handshake) and drain (output handshake):
  - accept, M empty: M <= new result.
  - accept and drain, S empty: M <= new result.
  - accept, M full, no drain: S <= new result; in_ready drops next cycle.
  - drain, S full: M <= S, S empties; any accept that cycle is blocked because in_ready=0.
  - drain only, S empty: M empties (out_valid=0).
- Stability: out_* are held stable while out_valid && !out_ready.
- Ordering: results emerge strictly in acceptance order; none are lost or duplicated.
- Opcodes 6 and 7 ignore in_b.
- out_zero and out_parity are computed from the result at capture time and stored with it in M/S.
- Counter: txn_count increments on every input handshake and saturates at 2^CNT_W-1 (no wrap).
- Reset mid-operation:
  - Any buffered result is discarded and txn_count clears immediately.
  - No out_valid pulse appears on release.
- Inputs while !in_valid are don't-care; X on in_a/in_b is never captured.

Decomposition:
- Package gate_array_pkg holds:
  - opcode enum constants OP_AND…OP_PASS (3 bits)
  - result record: y, op, zero, parity
- One natural sub-module, gate_array_fn: purely combinational (a, b, op) -> y/zero/parity.
- gate_array_fn is instantiated once at the input. Top-level RTL contains only the M/S buffer control and the counter.

Test Plan:
- All opcodes, WIDTH=8, a=8'hC5, b=8'h3A, out_ready=1 -> one cycle after each accept:
  - AND=00 (zero=1), OR=FF, NAND=FF, NOR=00, XOR=FF, XNOR=00, NOT A=3A, PASS=C5
  - parity: 0 for all 00/FF results; 0 for 3A; 0 for C5
- Back-to-back: 16 consecutive transactions with in_valid=1 and out_ready=1 -> in_ready stays 1, 16 results in 16 consecutive cycles, in order, txn_count=16.
- Backpressure: hold out_ready=0, issue 3 transactions ->
  - first two accepted (M then S), in_ready=0 from the cycle after the second
  - out_* stable
  - raising out_ready drains both in order; third accepted when in_ready returns
- Reset mid-stream: assert rst_n=0 asynchronously with M and S full -> out_valid=0 and txn_count=0 immediately; no residual result after rst_n=1.
- Counter saturation with CNT_W=4: 20 accepted transactions -> txn_count holds 15 from the 15th onward.
- Width generality with WIDTH=1 and WIDTH=32: random operands/opcodes against a reference model; all results match, and out_zero/out_parity are correct.
